// File: rtl/proc_mem_nport.sv
// rtl/proc_mem_nport.sv - multi-port round-robin arbitrated single-ported word memory
//
// Purpose:
//   NUM_PORTS request channels share one single-ported, word-addressed SRAM
//   array. A combinational round-robin arbiter grants at most one request per
//   cycle. The response (read data or write ack) is registered and appears
//   exactly one cycle after the transfer.
//
// Optional feature:
//   PROC_MEM_NPORT_ERR_EN - adds a sticky access-error flag (err, err_port) for
//   misaligned or out-of-range transfers. Misaligned accesses are then dropped.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   req_val     - per-port request valid
//   req_rdy     - per-port grant (one-hot or zero, forced to 0 during rst)
//   req_type    - per-port type, 0 = read, 1 = write
//   req_addr    - packed byte addresses, port p at [32p+31:32p]
//   req_wdata   - packed write data, port p at [DATA_W*p+DATA_W-1:DATA_W*p]
//   resp_val    - per-port response valid (one-hot or zero)
//   resp_rdata  - read data for the responding port, 0 for write acks
//   resp_port   - index of the responding port
//   err         - (ERR_EN only) sticky access-error flag
//   err_port    - (ERR_EN only) port of the first offending transfer

module proc_mem_nport #(
  parameter int NUM_PORTS   = 3,
  parameter int DEPTH_WORDS = 256,
  parameter int DATA_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         req_val,
  output logic [NUM_PORTS-1:0]         req_rdy,
  input  logic [NUM_PORTS-1:0]         req_type,
  input  logic [NUM_PORTS*32-1:0]      req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]         resp_val,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic [$clog2(NUM_PORTS)-1:0] resp_port
`ifdef PROC_MEM_NPORT_ERR_EN
  ,
  output logic                         err,
  output logic [$clog2(NUM_PORTS)-1:0] err_port
`endif
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     gnt_idx;
  logic              xfer;

  logic [31:0]       addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];

  logic [31:0]       addr_g;
  logic [DATA_W-1:0] wdata_g;
  logic              type_g;
  logic [AW-1:0]     word_idx;
  logic              out_of_range;
  logic              access_ok;
  logic              we;
  logic              rd_ok;

  logic [NUM_PORTS-1:0] resp_val_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [PW-1:0]        port_q;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*32 +: 32];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // Round-robin scan starting at ptr_q, ascending with wrap. The first
  // requesting port wins. Nothing is granted while rst is high.
  always_comb begin
    int p;
    p       = 0;
    xfer    = 1'b0;
    gnt_idx = '0;
    req_rdy = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p = int'(ptr_q) + i;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!xfer && req_val[PW'(p)]) begin
        xfer    = 1'b1;
        gnt_idx = PW'(p);
      end
    end
    if (rst) xfer = 1'b0;
    if (xfer) req_rdy[gnt_idx] = 1'b1;
  end

  assign addr_g       = addr_arr[gnt_idx];
  assign wdata_g      = wdata_arr[gnt_idx];
  assign type_g       = req_type[gnt_idx];
  assign word_idx     = addr_g[AW+1:2];
  assign out_of_range = |addr_g[31:AW+2];

`ifdef PROC_MEM_NPORT_ERR_EN
  assign access_ok = !out_of_range && (addr_g[1:0] == 2'b00);
`else
  // Byte offset bits carry no meaning without the error feature.
  logic unused_ok;
  assign unused_ok = ^addr_g[1:0];
  assign access_ok = !out_of_range;
`endif

  assign we    = xfer && type_g && access_ok;
  assign rd_ok = xfer && !type_g && access_ok;

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[word_idx] <= wdata_g;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      resp_val_q <= '0;
      rdata_q    <= '0;
      port_q     <= '0;
    end else begin
      resp_val_q <= req_rdy;
      rdata_q    <= rd_ok ? mem[word_idx] : '0;
      if (xfer) begin
        port_q <= gnt_idx;
        ptr_q  <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // A response due in a cycle where rst is high is suppressed; the write
  // behind it has already been committed.
  assign resp_val   = rst ? '0 : resp_val_q;
  assign resp_rdata = rst ? '0 : rdata_q;
  assign resp_port  = rst ? '0 : port_q;

`ifdef PROC_MEM_NPORT_ERR_EN
  logic          err_q;
  logic [PW-1:0] err_port_q;

  // Sticky; only the first offender's port is recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_port_q <= '0;
    end else if (xfer && !access_ok && !err_q) begin
      err_q      <= 1'b1;
      err_port_q <= gnt_idx;
    end
  end

  assign err      = err_q;
  assign err_port = err_port_q;
`endif

endmodule

// File: tb/tb_proc_mem_nport.sv
// tb/tb_proc_mem_nport.sv - self-checking bench for proc_mem_nport

module tb_proc_mem_nport;

  localparam int NP    = 3;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req_val;
  logic [NP-1:0] req_rdy;
  logic [NP-1:0] req_type;
  logic [NP*32-1:0] req_addr;
  logic [NP*32-1:0] req_wdata;
  logic [NP-1:0] resp_val;
  logic [31:0]   resp_rdata;
  logic [1:0]    resp_port;
`ifdef PROC_MEM_NPORT_ERR_EN
  logic          err;
  logic [1:0]    err_port;
`endif

  always #5 clk = ~clk;

  proc_mem_nport #(.NUM_PORTS(NP), .DEPTH_WORDS(DEPTH), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_val   (resp_val),
    .resp_rdata (resp_rdata),
    .resp_port  (resp_port)
`ifdef PROC_MEM_NPORT_ERR_EN
    ,
    .err        (err),
    .err_port   (err_port)
`endif
  );

  // Reference model: memory contents, round-robin pointer, pending response.
  logic [31:0] mem_m [DEPTH];
  int          ptr_m;
  logic [NP-1:0] pv;
  int          pport;
  logic [31:0] prdata;

  // Requester slots: a request stays presented until it is granted.
  logic        s_act  [NP];
  logic        s_typ  [NP];
  logic [31:0] s_addr [NP];
  logic [31:0] s_wd   [NP];

  int tests;
  int fails;
  logic [NP-1:0] last_val;
  logic [NP-1:0] last_rdy;
  logic [31:0]   last_rdata;
  logic [31:0]   last_port;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic typ, input logic [31:0] a, input logic [31:0] d);
    s_act[p]  = 1'b1;
    s_typ[p]  = typ;
    s_addr[p] = a;
    s_wd[p]   = d;
  endtask

  // One clock cycle; entered and left 1ns after a rising edge.
  task automatic cycle(input logic r);
    int g;
    int p;
    logic [31:0] a;
    logic [31:0] w;
    rst = r;
    for (int k = 0; k < NP; k++) begin
      req_val[k]           = s_act[k];
      req_type[k]          = s_typ[k];
      req_addr[k*32 +: 32]  = s_addr[k];
      req_wdata[k*32 +: 32] = s_wd[k];
    end
    #1;
    last_val   = resp_val;
    last_rdata = resp_rdata;
    last_port  = {30'b0, resp_port};
    if (r) begin
      chk("resp_val_rst", {29'b0, resp_val}, 32'h0);
      chk("resp_rdata_rst", resp_rdata, 32'h0);
      chk("resp_port_rst", {30'b0, resp_port}, 32'h0);
    end else begin
      chk("resp_val", {29'b0, resp_val}, {29'b0, pv});
      if (pv != '0) begin
        chk("resp_port", {30'b0, resp_port}, pport);
        chk("resp_rdata", resp_rdata, prdata);
      end
    end
    g = -1;
    if (!r) begin
      for (int i = 0; i < NP; i++) begin
        p = (ptr_m + i) % NP;
        if (g < 0 && s_act[p]) g = p;
      end
    end
    #3;
    last_rdy = req_rdy;
    chk("req_rdy", {29'b0, req_rdy}, (g >= 0) ? (32'h1 << g) : 32'h0);
    pv = '0;
    if (r) begin
      ptr_m = 0;
    end else if (g >= 0) begin
      a = s_addr[g];
      w = a >> 2;
      if (s_typ[g]) begin
        if (w < DEPTH) mem_m[w] = s_wd[g];
        prdata = 32'h0;
      end else begin
        prdata = (w < DEPTH) ? mem_m[w] : 32'h0;
      end
      pv       = NP'(1) << g;
      pport    = g;
      ptr_m    = (g + 1) % NP;
      s_act[g] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_active();
    logic a;
    a = 1'b0;
    for (int k = 0; k < NP; k++) a = a | s_act[k];
    return a;
  endfunction

  task automatic drain();
    for (int k = 0; k < 20 && any_active(); k++) cycle(1'b0);
    chk("drain_timeout", {31'b0, any_active()}, 32'h0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    ptr_m = 0;
    pv    = '0;
    pport = 0;
    prdata = '0;
    rst = 1'b1;
    req_val = '0;
    req_type = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int k = 0; k < NP; k++) begin
      s_act[k] = 1'b0; s_typ[k] = 1'b0; s_addr[k] = '0; s_wd[k] = '0;
    end
    for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;

    @(posedge clk);
    #1;
    cycle(1'b1);
    cycle(1'b1);

    // Preload words 0..15 with value index+1 through port 2.
    for (int k = 0; k < 16; k++) begin
      set_req(2, 1'b1, k * 4, k + 1);
      cycle(1'b0);
    end
    cycle(1'b0);

    // Port 1 write then read of the same word.
    set_req(1, 1'b1, 32'h10, 32'hDEADBEEF);
    cycle(1'b0);
    set_req(1, 1'b0, 32'h10, 32'h0);
    cycle(1'b0);
    chk("beef_ack_rdata", last_rdata, 32'h0);
    cycle(1'b0);
    chk("beef_val", {29'b0, last_val}, 32'h2);
    chk("beef_rdata", last_rdata, 32'hDEADBEEF);
    chk("beef_port", last_port, 32'h1);

    // All three ports hold reads right after reset.
    cycle(1'b1);
    set_req(0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 32'h4, 32'h0);
    set_req(2, 1'b0, 32'h8, 32'h0);
    cycle(1'b0);
    chk("rr_first_grant", {29'b0, last_rdy}, 32'h1);
    drain();
    cycle(1'b0);
    chk("rr_last_port", last_port, 32'h2);
    chk("rr_last_rdata", last_rdata, 32'h3);

    // Wrap: port 2 alone, then 0 and 2 together.
    set_req(2, 1'b0, 32'h8, 32'h0);
    cycle(1'b0);
    set_req(0, 1'b0, 32'h0, 32'h0);
    set_req(2, 1'b0, 32'h4, 32'h0);
    cycle(1'b0);
    chk("wrap_first", {29'b0, last_rdy}, 32'h1);
    cycle(1'b0);
    chk("wrap_second", {29'b0, last_rdy}, 32'h4);
    cycle(1'b0);

    // Out-of-range write is dropped, read returns 0.
    set_req(0, 1'b1, 32'h400, 32'h5);
    cycle(1'b0);
    set_req(0, 1'b0, 32'h400, 32'h0);
    cycle(1'b0);
    set_req(0, 1'b0, 32'h0, 32'h0);
    cycle(1'b0);
    chk("oor_rdata", last_rdata, 32'h0);
    cycle(1'b0);
    chk("word0_kept", last_rdata, 32'h1);

    // Reset mid-operation.
    set_req(1, 1'b1, 32'hC, 32'hA5A5A5A5);
    cycle(1'b0);
    set_req(0, 1'b0, 32'h0, 32'h0);
    cycle(1'b0);
    set_req(2, 1'b1, 32'hC, 32'h00000BAD);
    cycle(1'b1);
    chk("rst_suppress", {29'b0, last_val}, 32'h0);
    s_act[2] = 1'b0;
    set_req(0, 1'b0, 32'hC, 32'h0);
    cycle(1'b0);
    cycle(1'b0);
    chk("rst_write_kept", last_rdata, 32'hA5A5A5A5);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NP; k++) begin
        if (!s_act[k] && ($urandom % 3 == 0)) begin
          logic [31:0] a;
          a = ($urandom % 16) * 4;
          if ($urandom % 8 == 0) a = a + 32'h400;
          set_req(k, 1'($urandom % 2), a, $urandom);
        end
      end
      cycle(($urandom % 100) == 0);
    end
    drain();
    cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
